// File: rtl/debug_in_sampler.sv
// Periodic sampler for a 32-bit debug input word. Samples are queued in a small FIFO
// and read out over an Avalon-MM slave. A level interrupt reports pending data or overflow.
module debug_in_sampler #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] in_port,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PERIOD = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_DATA   = 3'd3;
  localparam logic [2:0] A_LIVE   = 3'd4;

  logic          en, irq_en, ovf;
  logic [31:0]   period, cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;

  logic wr_ctrl, wr_per, wr_stat, flush;
  logic empty, full, strobe, pop, push_req, push, ovf_evt;
  logic ovf_nxt, irq_en_nxt;
  logic [6:0]  count7;
  logic [31:0] status_w, head_w;

  always_comb begin
    wr_ctrl    = write && (address == A_CTRL);
    wr_per     = write && (address == A_PERIOD);
    wr_stat    = write && (address == A_STATUS);
    flush      = wr_ctrl && writedata[2];
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    strobe     = en && (cnt == '0);
    pop        = read && (address == A_DATA) && !empty;
    // A flush swallows the strobe of the same edge.
    push_req   = strobe && !flush;
    push       = push_req && (!full || pop);
    ovf_evt    = push_req && full && !pop;
    count_nxt  = flush ? '0 : count + CW'(push) - CW'(pop);
    // A new overflow event beats a same-cycle W1C clear.
    ovf_nxt    = flush   ? 1'b0 :
                 ovf_evt ? 1'b1 :
                 (wr_stat && writedata[18]) ? 1'b0 : ovf;
    irq_en_nxt = wr_ctrl ? writedata[1] : irq_en;
    count7     = 7'(count);
    status_w   = {13'd0, ovf, full, empty, 9'd0, count7};
    head_w     = empty ? 32'd0 : mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
      period <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= writedata[0];
        irq_en <= writedata[1];
      end
      if (wr_per) period <= writedata;
    end
  end

  // Sample timer: held at PERIOD while idle so the first strobe lands PERIOD+1 edges after enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     cnt <= '0;
    else if (wr_per)                  cnt <= writedata;
    else if (!en || flush || strobe)  cnt <= period;
    else                              cnt <= cnt - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_port;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      ovf   <= ovf_nxt;
      irq   <= irq_en_nxt & ((count_nxt != '0) | ovf_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else if (read) begin
      case (address)
        A_CTRL:   readdata <= {30'd0, irq_en, en};
        A_PERIOD: readdata <= period;
        A_STATUS: readdata <= status_w;
        A_DATA:   readdata <= head_w;
        A_LIVE:   readdata <= in_port;
        default:  readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_in_sampler.sv
// Directed bench for debug_in_sampler: reads queue their expected data, a monitor
// compares readdata the cycle after each read strobe.
module tb_debug_in_sampler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0, in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int vecs = 0, errs = 0;
  logic [31:0] exp_q [$];
  string       nm_q  [$];
  logic [31:0] vb;

  always #5 clk = ~clk;

  debug_in_sampler #(.DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock per call; in_port steps every cycle so sample values track edge numbers.
  task automatic cyc(input logic [2:0] a, input logic r, input logic w, input logic [31:0] d,
                     input logic [31:0] e, input string nm);
    address = a; read = r; write = w; writedata = d; in_port = in_port + 32'd1;
    if (r) begin exp_q.push_back(e); nm_q.push_back(nm); end
    @(negedge clk);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'd0, 1'b0, 1'b0, 32'd0, 32'd0, "");
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(a, 1'b0, 1'b1, d, 32'd0, "");
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    cyc(a, 1'b1, 1'b0, 32'd0, e, nm);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (read) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL unexpected_read: got %h expected no read", readdata);
        end else begin
          chk(nm_q.pop_front(), readdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd1, 32'd0, "rst_period");
    rd(3'd2, 32'h0001_0000, "rst_status");
    rd(3'd3, 32'd0, "rst_data");
    rd(3'd5, 32'd0, "unmapped");

    // PERIOD=3: strobes every 4 edges, first 4 edges after enable
    wr(3'd1, 32'd3);
    rd(3'd1, 32'd3, "t31_period");
    wr(3'd0, 32'd1); vb = in_port;
    idle(2);
    rd(3'd2, 32'h0001_0000, "t31_before_first");
    idle(1);
    rd(3'd2, 32'd1, "t31_first");
    idle(8);
    wr(3'd0, 32'd0);
    rd(3'd2, 32'd3, "t31_count");
    rd(3'd3, vb + 32'd4, "t31_s0");
    rd(3'd3, vb + 32'd8, "t31_s1");
    rd(3'd3, vb + 32'd12, "t31_s2");
    rd(3'd3, 32'd0, "t31_empty");

    // PERIOD=0 for 10 edges: full + overflow, first 8 samples kept
    wr(3'd0, 32'd4);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1); vb = in_port;
    idle(9);
    wr(3'd0, 32'd0);
    rd(3'd2, 32'h0006_0008, "t32_status");
    for (int i = 1; i <= 8; i++) rd(3'd3, vb + 32'(i), "t32_data");
    rd(3'd3, 32'd0, "t32_empty");
    rd(3'd2, 32'h0005_0000, "t32_ovf_sticky");
    wr(3'd2, 32'h0004_0000);
    rd(3'd2, 32'h0001_0000, "t32_w1c");

    // PERIOD=1: full FIFO, strobe + pop same edge, then overflow racing a W1C clear
    wr(3'd1, 32'd1);
    wr(3'd0, 32'd1); vb = in_port;
    idle(17);
    rd(3'd3, vb + 32'd2, "t33_pop_full");
    rd(3'd2, 32'h0002_0008, "t33_no_ovf");
    wr(3'd2, 32'h0004_0000);
    wr(3'd0, 32'd0);
    rd(3'd2, 32'h0006_0008, "t33_ovf_wins");
    for (int k = 2; k <= 9; k++) rd(3'd3, vb + 32'(2 * k), "t33_data");
    rd(3'd2, 32'h0005_0000, "t33_drained");
    wr(3'd2, 32'h0004_0000);

    // interrupt behaviour
    wr(3'd0, 32'd4);
    wr(3'd1, 32'd2);
    wr(3'd0, 32'd3); vb = in_port;
    idle(2);
    chk("t34_irq_idle", {31'd0, irq}, 32'd0);
    wr(3'd0, 32'd2);
    chk("t34_irq_push", {31'd0, irq}, 32'd1);
    rd(3'd3, vb + 32'd3, "t34_data");
    chk("t34_irq_pop", {31'd0, irq}, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd3); vb = in_port;
    idle(8);
    wr(3'd0, 32'd2);
    for (int i = 1; i <= 8; i++) rd(3'd3, vb + 32'(i), "t34_drain");
    chk("t34_irq_ovf", {31'd0, irq}, 32'd1);
    wr(3'd2, 32'h0004_0000);
    chk("t34_irq_clr", {31'd0, irq}, 32'd0);

    // flush with 5 entries, strobe on the flush edge discarded
    wr(3'd0, 32'd4);
    wr(3'd0, 32'd1);
    idle(4);
    rd(3'd2, 32'd4, "t35_pre");
    wr(3'd0, 32'd4);
    rd(3'd2, 32'h0001_0000, "t35_flushed");
    rd(3'd3, 32'd0, "t35_data");
    rd(3'd4, in_port + 32'd1, "t35_live");
    idle(3);
    rd(3'd2, 32'h0001_0000, "t35_idle");

    // async reset with 3 entries pending
    wr(3'd0, 32'd3);
    idle(3);
    chk("t36_irq_pre", {31'd0, irq}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t36_irq_rst", {31'd0, irq}, 32'd0);
    chk("t36_rd_rst", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, 32'd0, "t36_ctrl");
    rd(3'd1, 32'd0, "t36_period");
    rd(3'd2, 32'h0001_0000, "t36_status");
    rd(3'd3, 32'd0, "t36_data");
    idle(5);
    rd(3'd2, 32'h0001_0000, "t36_no_strobe");
    chk("t36_irq_after", {31'd0, irq}, 32'd0);

    idle(2);
    if (exp_q.size() != 0) begin
      vecs++; errs++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/debug_in_sampler.md
DEBUG_IN_SAMPLER -- requirements
Module: debug_in_sampler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in words (power of two, 2..64).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port address  input  3  Avalon-MM word address.
REQ-005 SHALL have port read  input  1  Avalon-MM read strobe.
REQ-006 SHALL have port write  input  1  Avalon-MM write strobe.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port readdata  output  32  registered read data.
REQ-009 SHALL have port in_port  input  32  debug input word, synchronous to clk.
REQ-010 SHALL have port irq  output  1  registered level interrupt.

Function
REQ-011 Register map: 0 CTRL (RW), 1 PERIOD (RW), 2 STATUS (RO, W1C bit 18), 3 DATA (RO, pop-on-read), 4 LIVE (RO); addresses 5-7 read 0, writes ignored.
REQ-012 CTRL: bit0 enable, bit1 irq_en, bit2 flush (write-1, self-clearing, reads 0); other bits read 0.
REQ-013 readdata SHALL update on the clock edge after read=1 (1-cycle latency) and hold its value when read=0.
REQ-014 Sample timer: 32-bit down-counter; strobe when enable=1 and counter=0, then reload PERIOD; otherwise decrement while enable=1.
REQ-015 Counter SHALL be loaded with PERIOD while enable=0 and on any PERIOD write; first strobe occurs PERIOD+1 cycles after enable rises.
REQ-016 PERIOD=0 SHALL give a strobe every cycle while enabled.
REQ-017 On strobe, in_port value at that edge SHALL be pushed into the FIFO.
REQ-018 Strobe while FIFO full and no pop same cycle: sample dropped, overflow (STATUS bit18) set sticky.
REQ-019 Read of DATA: returns FIFO head and pops it in the same cycle; if empty returns 0 and state unchanged.
REQ-020 Simultaneous push and pop when full: both succeed, count unchanged, overflow not set.
REQ-021 Simultaneous push and pop when empty: read returns 0, push succeeds, count becomes 1.
REQ-022 STATUS: bits[6:0] count (0..DEPTH), bit16 empty, bit17 full, bit18 overflow; others 0.
REQ-023 Writing STATUS with writedata bit18=1 clears overflow; a same-cycle new overflow event wins (stays set).
REQ-024 Flush SHALL empty FIFO, clear overflow and reload counter in one cycle; a same-cycle strobe is discarded.
REQ-025 LIVE read returns in_port sampled at the read edge.
REQ-026 Pointers wrap modulo DEPTH; count tracked separately so full and empty are unambiguous.
REQ-027 irq SHALL be registered: irq <= irq_en & (!empty | overflow), evaluated from next-state values.

Reset
REQ-028 On reset_n=0 asynchronously: CTRL=0, PERIOD=0, counter=0, FIFO empty, pointers=0, overflow=0, readdata=0, irq=0.
REQ-029 FIFO storage contents need not be reset; no output SHALL expose un-popped storage after reset.
REQ-030 Reset mid-operation SHALL discard pending samples; sampling resumes only after enable is rewritten to 1.

Verification
REQ-031 PERIOD=3, in_port counter incrementing each cycle, enable=1 -> strobes every 4 cycles, DATA reads return values spaced by 4, first at enable+4 cycles.
REQ-032 DEPTH=8, PERIOD=0, no reads for 10 cycles -> count=8, full=1, overflow=1, DATA reads return the first 8 samples in order then 0.
REQ-033 FIFO full with strobe and DATA read in same cycle -> count stays 8, overflow stays 0, oldest word returned.
REQ-034 irq_en=1, one sample pushed -> irq=1 next cycle; pop it -> irq=0; force overflow, drain FIFO -> irq stays 1 until STATUS write 0x00040000.
REQ-035 Flush written with 5 entries -> STATUS reads 0x00010000 next read.
REQ-036 Assert reset_n=0 with 3 entries and enable=1 -> all registers 0, irq=0, DATA reads 0, no strobes after release until CTRL written.
